registro_datos_mp: RTL and testbench

REGISTRO_DATOS_MP -- requirements
Module: registro_datos_mp

---
 rtl/registro_datos_mp.sv | 154 +++++++++++++++
 tb/tb_registro_datos_mp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/registro_datos_mp.sv
// Word register file with a byte-lane parallel write port (A), a serial
// byte-assembling write port (B) and one registered read port.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   hold_ctrl        1 = port B owns the array, port A writes are dropped
//   a_wr/a_addr/a_data/a_be    port A word write with byte enables
//   b_start/b_addr   load port B pointer, clear assembler
//   b_valid/b_byte   serial byte in, LSB-first packing
//   b_flush          commit a partial word, zero-padded
//   rd_en/rd_addr    read request; rd_data/rd_valid one cycle later
//   b_ptr, b_busy    port B word pointer, assembler holds bytes
//   collision        A and B hit the same word on the same edge
//   a_drop           port A write arrived while hold_ctrl=1
module registro_datos_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_ctrl,
    input  logic              a_wr,
    input  logic [AW-1:0]     a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [NB-1:0]     a_be,
    input  logic              b_start,
    input  logic [AW-1:0]     b_addr,
    input  logic              b_valid,
    input  logic [7:0]        b_byte,
    input  logic              b_flush,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW-1:0]     b_ptr,
    output logic              b_busy,
    output logic              collision,
    output logic              a_drop
);

    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } b_state_t;

    b_state_t          state, state_n;
    logic [CW-1:0]     count, count_n;
    logic [DATA_W-1:0] asm_word, word_n;
    logic [AW-1:0]     ptr_n;
    logic              commit;
    logic              a_we;
    logic              a_hit;

    logic [DATA_W-1:0] mem [DEPTH];

    assign b_busy = (state == FILL);
    assign a_we   = a_wr & ~hold_ctrl;
    // Same-word conflict: B owns the word, A's write is thrown away.
    assign a_hit  = a_we & commit & (a_addr == b_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            asm_word <= '0;
            b_ptr    <= '0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            asm_word <= word_n;
            b_ptr    <= ptr_n;
        end
    end

    // The COMMIT cycle writes the held word and, in the same cycle, can
    // already take lane 0 of the next word, so back-to-back bytes are
    // never stalled. The assembler is cleared at every word start,
    // which gives the zero padding on flush for free.
    always_comb begin
        state_n = state;
        count_n = count;
        word_n  = asm_word;
        ptr_n   = b_ptr;
        commit  = (state == COMMIT);
        if (commit) begin
            ptr_n   = b_ptr + AW'(1);
            word_n  = '0;
            count_n = '0;
            state_n = IDLE;
        end
        if (b_start) begin
            ptr_n   = b_addr;
            word_n  = '0;
            count_n = '0;
            state_n = IDLE;
        end else if (b_valid) begin
            for (int i = 0; i < NB; i++) begin
                if (count_n == CW'(i)) begin
                    word_n[8*i +: 8] = b_byte;
                end
            end
            count_n = count_n + CW'(1);
            if (count_n == CW'(NB) || b_flush) begin
                state_n = COMMIT;
            end else begin
                state_n = FILL;
            end
        end else if (b_flush && state == FILL) begin
            state_n = COMMIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (a_we && !a_hit) begin
                for (int j = 0; j < NB; j++) begin
                    if (a_be[j]) begin
                        mem[a_addr][8*j +: 8] <= a_data[8*j +: 8];
                    end
                end
            end
            if (commit) begin
                mem[b_ptr] <= asm_word;
            end
        end
    end

    // Read samples the array before this edge's writes land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            collision <= 1'b0;
            a_drop    <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
            rd_valid  <= rd_en;
            collision <= a_hit;
            a_drop    <= a_wr & hold_ctrl;
        end
    end

endmodule

// File: tb/tb_registro_datos_mp.sv
// Directed bench for registro_datos_mp: port A byte lanes, port B
// assembly/flush/wrap, collisions, drops and asynchronous reset.
module tb_registro_datos_mp;

    localparam int DW  = 32;
    localparam int DEP = 64;
    localparam int AW  = 6;
    localparam int NB  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hold_ctrl = 1'b0;
    logic          a_wr = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic [NB-1:0] a_be = '0;
    logic          b_start = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic          b_valid = 1'b0;
    logic [7:0]    b_byte = '0;
    logic          b_flush = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] b_ptr;
    logic          b_busy;
    logic          collision;
    logic          a_drop;

    int total = 0;
    int bad   = 0;

    registro_datos_mp #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold_ctrl (hold_ctrl),
        .a_wr      (a_wr),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_be      (a_be),
        .b_start   (b_start),
        .b_addr    (b_addr),
        .b_valid   (b_valid),
        .b_byte    (b_byte),
        .b_flush   (b_flush),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .b_ptr     (b_ptr),
        .b_busy    (b_busy),
        .collision (collision),
        .a_drop    (a_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                           input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic send_byte(input logic [7:0] v);
        b_valid = 1'b1;
        b_byte  = v;
        tick();
        b_valid = 1'b0;
    endtask

    task automatic start_b(input logic [AW-1:0] a);
        b_start = 1'b1;
        b_addr  = a;
        tick();
        b_start = 1'b0;
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #2;
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_b_ptr", 64'(b_ptr), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);
        chk("rst_collision", 64'(collision), 64'd0);
        chk("rst_a_drop", 64'(a_drop), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // every word reads zero, one cycle after each request
        for (int i = 0; i < DEP; i++) begin
            do_read(AW'(i), '0, "rst_mem");
        end
        tick();
        chk("rd_valid_drop", 64'(rd_valid), 64'd0);
        chk("rd_data_hold", 64'(rd_data), 64'd0);

        // byte-lane write over a prior word
        a_wr = 1'b1; a_addr = 6'd3; a_data = 32'h11223344; a_be = 4'hF;
        tick();
        a_data = 32'hAABBCCDD; a_be = 4'b0101;
        tick();
        a_wr = 1'b0;
        do_read(6'd3, 32'h11BB33DD, "a_lanes");

        // read and write on the same edge returns the old contents
        a_wr = 1'b1; a_addr = 6'd3; a_data = 32'hDEADBEEF; a_be = 4'hF;
        rd_en = 1'b1; rd_addr = 6'd3;
        tick();
        a_wr = 1'b0; rd_en = 1'b0;
        chk("rd_before_wr", 64'(rd_data), 64'h11BB33DD);
        do_read(6'd3, 32'hDEADBEEF, "rd_after_wr");

        // port B stream across the top address, wrapping to 0
        start_b(6'd63);
        chk("b_ptr_load", 64'(b_ptr), 64'd63);
        send_byte(8'h01);
        chk("b_busy_fill", 64'(b_busy), 64'd1);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("b_busy_commit", 64'(b_busy), 64'd0);
        send_byte(8'h05);
        chk("b_ptr_wrap", 64'(b_ptr), 64'd0);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        tick();
        chk("b_ptr_after2", 64'(b_ptr), 64'd1);
        chk("b_busy_idle", 64'(b_busy), 64'd0);
        do_read(6'd63, 32'h04030201, "b_word63");
        do_read(6'd0, 32'h08070605, "b_word0");

        // flush of a two-byte partial word
        start_b(6'd5);
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("flush_busy_pre", 64'(b_busy), 64'd1);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        tick();
        chk("flush_busy", 64'(b_busy), 64'd0);
        chk("flush_ptr", 64'(b_ptr), 64'd6);
        do_read(6'd5, 32'h0000BBAA, "flush_word");

        // flush in IDLE does nothing
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        tick();
        chk("flush_idle_ptr", 64'(b_ptr), 64'd6);

        // same-address collision: B wins
        start_b(6'd7);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        a_wr = 1'b1; a_addr = 6'd7; a_data = 32'hCAFEF00D; a_be = 4'hF;
        tick();
        a_wr = 1'b0;
        chk("coll_pulse", 64'(collision), 64'd1);
        tick();
        chk("coll_clear", 64'(collision), 64'd0);
        do_read(6'd7, 32'h44332211, "coll_word");

        // different addresses on the same edge both land
        start_b(6'd9);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hD4);
        a_wr = 1'b1; a_addr = 6'd10; a_data = 32'h55AA55AA; a_be = 4'hF;
        tick();
        a_wr = 1'b0;
        chk("nocoll", 64'(collision), 64'd0);
        do_read(6'd9, 32'hD4C3B2A1, "nocoll_b");
        do_read(6'd10, 32'h55AA55AA, "nocoll_a");

        // port A blocked under hold_ctrl
        hold_ctrl = 1'b1;
        a_wr = 1'b1; a_addr = 6'd7; a_data = 32'h0; a_be = 4'hF;
        tick();
        a_wr = 1'b0;
        chk("drop_pulse", 64'(a_drop), 64'd1);
        tick();
        chk("drop_clear", 64'(a_drop), 64'd0);
        do_read(6'd7, 32'h44332211, "drop_word");

        // port B still writes while hold_ctrl=1
        start_b(6'd12);
        send_byte(8'h9A);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        tick();
        hold_ctrl = 1'b0;
        do_read(6'd12, 32'h0000009A, "hold_b_word");

        // asynchronous reset in the middle of a word
        start_b(6'd20);
        send_byte(8'h5A);
        send_byte(8'hA5);
        chk("mid_busy", 64'(b_busy), 64'd1);
        chk("mid_ptr", 64'(b_ptr), 64'd20);
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(b_busy), 64'd0);
        chk("arst_ptr", 64'(b_ptr), 64'd0);
        chk("arst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_b_busy_rel", 64'(b_busy), 64'd0);

        // first edge after release accepts a write
        a_wr = 1'b1; a_addr = 6'd1; a_data = 32'h12345678; a_be = 4'hF;
        tick();
        a_wr = 1'b0;
        do_read(6'd1, 32'h12345678, "first_wr");
        do_read(6'd20, 32'h0, "arst_target");
        do_read(6'd7, 32'h0, "arst_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
